// File: rtl/key_index_encoder_if.sv
// Valid/ready event channel carrying the encoded key position and multi-press flag.
interface key_index_encoder_if;
  logic [2:0] number;
  logic       multi;
  logic       valid;
  logic       ready;

  modport master (output number, output multi, output valid, input ready);
  modport slave  (input number, input multi, input valid, output ready);
endinterface

// File: rtl/key_index_encoder.sv
// Sync + debounce 8 key lines, priority-encode new presses (lowest wins); valid rises 3+DB_CYCLES edges after a change.
// One-deep holding register: a press arriving while the held event is unconsumed is dropped and flagged in sticky overrun.
module key_index_encoder #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 keys_i,
  input  logic                       clr_overrun_i,
  output logic                       overrun_o,
  key_index_encoder_if.master        out_if
);

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] s1_q, s2_q;
  logic [7:0] db_q, db_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] press_q, press_d;
  logic [2:0] number_q, number_d;
  logic       multi_q, multi_d;
  logic       overrun_q, overrun_d;
  logic [2:0] idx;
  logic       mul;

  // s1 != s2 means s2 takes a new value on this edge, so its stable run restarts.
  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    press_d = '0;
    if ((s2_q == db_q) || (s1_q != s2_q)) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      db_d    = s2_q;
      cnt_d   = '0;
      press_d = s2_q & ~db_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (press_q[i]) idx = 3'(i);
    end
    mul = (press_q & (press_q - 8'd1)) != 8'd0;
  end

  always_comb begin
    state_d   = state_q;
    number_d  = number_q;
    multi_d   = multi_q;
    overrun_d = overrun_q & ~clr_overrun_i;
    case (state_q)
      IDLE: begin
        if (press_q != 8'd0) begin
          number_d = idx;
          multi_d  = mul;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_if.ready) begin
          if (press_q != 8'd0) begin
            number_d = idx;
            multi_d  = mul;
          end else begin
            state_d = IDLE;
          end
        end else if (press_q != 8'd0) begin
          // Set beats a simultaneous clear.
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      number_q  <= '0;
      multi_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= keys_i;
      s2_q      <= s1_q;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      number_q  <= number_d;
      multi_q   <= multi_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_if.number = number_q;
  assign out_if.multi  = multi_q;
  assign out_if.valid  = (state_q == HOLD);
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_key_index_encoder.sv
// Directed bench for key_index_encoder: table of single presses plus bounce, backpressure and reset sequences.
module tb_key_index_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keys = 8'd0;
  logic       clr = 1'b0;
  logic       overrun;

  key_index_encoder_if u_if ();

  key_index_encoder #(.DB_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .keys_i        (keys),
    .clr_overrun_i (clr),
    .overrun_o     (overrun),
    .out_if        (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] keys;
    int         exp_num;
    int         exp_mul;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Counts rising edges from the current negedge until valid is seen; 0 on timeout.
  task automatic wait_valid(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (u_if.valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (u_if.valid) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;

    vecs[0] = '{keys: 8'h20, exp_num: 5, exp_mul: 0};
    vecs[1] = '{keys: 8'h28, exp_num: 3, exp_mul: 1};
    vecs[2] = '{keys: 8'h01, exp_num: 0, exp_mul: 0};
    vecs[3] = '{keys: 8'h80, exp_num: 7, exp_mul: 0};
    vecs[4] = '{keys: 8'hFF, exp_num: 0, exp_mul: 1};
    vecs[5] = '{keys: 8'h06, exp_num: 1, exp_mul: 1};

    u_if.ready = 1'b1;
    rst_n = 1'b0;
    keys = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_number", int'(u_if.number), 0);
    check("rst_valid", int'(u_if.valid), 0);
    check("rst_multi", int'(u_if.multi), 0);
    check("rst_overrun", int'(overrun), 0);
    keys = 8'd0;
    rst_n = 1'b1;
    count_valid(20, seen);
    check("idle_after_reset", seen, 0);

    for (int v = 0; v < 6; v++) begin
      keys = vecs[v].keys;
      wait_valid(20, lat);
      check($sformatf("vec%0d_latency", v), lat, 7);
      check($sformatf("vec%0d_number", v), int'(u_if.number), vecs[v].exp_num);
      check($sformatf("vec%0d_multi", v), int'(u_if.multi), vecs[v].exp_mul);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_one_cycle", v), int'(u_if.valid), 0);
      count_valid(12, seen);
      check($sformatf("vec%0d_no_repeat", v), seen, 0);
      keys = 8'd0;
      count_valid(12, seen);
      check($sformatf("vec%0d_release_silent", v), seen, 0);
    end

    // Bounce on bit 2: stable runs of 2 cycles must never reach the debounce threshold.
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      keys = (t % 2 == 0) ? 8'h04 : 8'h00;
      repeat (2) begin
        @(posedge clk);
        @(negedge clk);
        if (u_if.valid) seen++;
      end
    end
    check("bounce_silent", seen, 0);
    keys = 8'h04;
    wait_valid(20, lat);
    check("bounce_latency", lat, 7);
    check("bounce_number", int'(u_if.number), 2);
    @(posedge clk);
    @(negedge clk);
    count_valid(12, seen);
    check("bounce_single_event", seen, 0);
    keys = 8'd0;
    repeat (12) @(negedge clk);

    // Backpressure and overrun.
    u_if.ready = 1'b0;
    keys = 8'h02;
    wait_valid(20, lat);
    check("bp_latency", lat, 7);
    check("bp_number", int'(u_if.number), 1);
    keys = 8'd0;
    repeat (10) @(negedge clk);
    keys = 8'h40;
    repeat (10) @(negedge clk);
    check("bp_number_held", int'(u_if.number), 1);
    check("bp_valid_held", int'(u_if.valid), 1);
    check("bp_overrun_set", int'(overrun), 1);
    u_if.ready = 1'b1;
    @(negedge clk);
    check("bp_consumed", int'(u_if.valid), 0);
    count_valid(10, seen);
    check("bp_dropped_never_seen", seen, 0);
    check("bp_overrun_sticky", int'(overrun), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("bp_overrun_cleared", int'(overrun), 0);

    // Clear on the same edge as a fresh drop: set wins.
    u_if.ready = 1'b0;
    keys = 8'd0;
    repeat (10) @(negedge clk);
    keys = 8'h08;
    wait_valid(20, lat);
    check("sim_latency", lat, 7);
    check("sim_number", int'(u_if.number), 3);
    keys = 8'd0;
    repeat (10) @(negedge clk);
    keys = 8'h20;
    repeat (6) @(negedge clk);
    check("sim_overrun_before", int'(overrun), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("sim_set_wins", int'(overrun), 1);
    check("sim_number_held", int'(u_if.number), 3);
    u_if.ready = 1'b1;
    @(negedge clk);
    check("sim_consumed", int'(u_if.valid), 0);
    keys = 8'd0;
    repeat (10) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // Reset while holding an event with bit 4 still pressed.
    u_if.ready = 1'b0;
    keys = 8'h10;
    wait_valid(20, lat);
    check("mid_latency", lat, 7);
    check("mid_number", int'(u_if.number), 4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_valid", int'(u_if.valid), 0);
    check("mid_async_number", int'(u_if.number), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(20, lat);
    check("post_rst_latency", lat, 7);
    check("post_rst_number", int'(u_if.number), 4);
    check("post_rst_multi", int'(u_if.multi), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
